ks_note_sequencer: RTL and testbench

Step sequencer that plays the Karplus-Strong string voice from a small pattern memory. Each step re-initialises the string, loads a period and issues a pluck gate. All sequencing advances on a tick strobe that the integrating design aligns with the string's slow clock domain. Pattern entries, tempo, gate length and loop length come from SPI config registers; start and stop come from config bits or pads.

---
 rtl/ks_note_sequencer.sv | 170 +++++++++++++++++
 tb/tb_ks_note_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_note_sequencer.sv
// ============================================================================
// Module   : ks_note_sequencer
// Brief    : Tick-driven step sequencer feeding period/re-init/pluck/accent
//            to the Karplus-Strong string voice from a small pattern memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ks_note_sequencer #(
   parameter int STEPS    = 16,
   parameter int STEP_W   = 4,
   parameter int PERIOD_W = 4,
   parameter int TEMPO_W  = 8,
   parameter int GATE_W   = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                tick_i,
   input  logic                start_i,
   input  logic                stop_i,
   input  logic                loop_en_i,
   input  logic [STEP_W-1:0]   last_step_i,
   input  logic [TEMPO_W-1:0]  tempo_i,
   input  logic [GATE_W-1:0]   gate_len_i,
   input  logic                wr_en_i,
   input  logic [STEP_W-1:0]   wr_addr_i,
   input  logic [PERIOD_W+1:0] wr_data_i,
   output logic [PERIOD_W-1:0] period_o,
   output logic                string_rst_o,
   output logic                pluck_o,
   output logic                accent_o,
   output logic [STEP_W-1:0]   step_o,
   output logic                busy_o,
   output logic                done_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state, w_state_nx;
   logic [STEP_W-1:0]   r_step, w_step_nx;
   logic [TEMPO_W-1:0]  r_tcnt, w_tcnt_nx;
   logic                r_note, w_note_nx;
   logic [PERIOD_W-1:0] w_period_nx;
   logic                w_srst_nx, w_pluck_nx, w_accent_nx, w_busy_nx, w_done_nx;
   logic [PERIOD_W+1:0] r_mem [STEPS];
   logic [PERIOD_W+1:0] w_entry;
   logic [TEMPO_W-1:0]  w_tempo_eff;
   logic                w_in_gate;

   // Entry layout: {note_on, accent, period}; all-zero is a rest.
   assign w_entry     = r_mem[r_step];
   assign w_tempo_eff = (tempo_i == '0) ? TEMPO_W'(1) : tempo_i;
   assign w_in_gate   = (r_tcnt != '0) &&
                        ({{TEMPO_W{1'b0}}, gate_len_i} >= {{GATE_W{1'b0}}, r_tcnt});

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < STEPS; i++) r_mem[i] <= '0;
      end else if (wr_en_i) begin
         r_mem[wr_addr_i] <= wr_data_i;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_step_nx   = r_step;
      w_tcnt_nx   = r_tcnt;
      w_note_nx   = r_note;
      w_period_nx = period_o;
      w_srst_nx   = string_rst_o;
      w_pluck_nx  = pluck_o;
      w_accent_nx = accent_o;
      w_busy_nx   = busy_o;
      w_done_nx   = 1'b0;

      if (stop_i && (r_state != S_IDLE)) begin
         w_state_nx  = S_IDLE;
         w_note_nx   = 1'b0;
         w_srst_nx   = 1'b0;
         w_pluck_nx  = 1'b0;
         w_accent_nx = 1'b0;
         w_busy_nx   = 1'b0;
      end else if (start_i && !stop_i) begin
         w_state_nx  = S_RUN;
         w_step_nx   = '0;
         w_tcnt_nx   = '0;
         w_note_nx   = 1'b0;
         w_srst_nx   = 1'b0;
         w_pluck_nx  = 1'b0;
         w_accent_nx = 1'b0;
         w_busy_nx   = 1'b1;
      end else begin
         case (r_state)
            S_RUN: begin
               if (tick_i) begin
                  w_pluck_nx = r_note && w_in_gate;
                  if (r_tcnt == '0) begin
                     w_srst_nx   = w_entry[PERIOD_W+1];
                     w_accent_nx = w_entry[PERIOD_W];
                     w_note_nx   = w_entry[PERIOD_W+1];
                     if (w_entry[PERIOD_W+1]) w_period_nx = w_entry[PERIOD_W-1:0];
                  end else begin
                     w_srst_nx = 1'b0;
                  end
                  if (r_tcnt < w_tempo_eff) begin
                     w_tcnt_nx = r_tcnt + TEMPO_W'(1);
                  end else begin
                     w_tcnt_nx = '0;
                     if (r_step >= last_step_i) begin
                        if (loop_en_i) begin
                           w_step_nx = '0;
                        end else begin
                           w_state_nx  = S_DONE;
                           w_done_nx   = 1'b1;
                           w_busy_nx   = 1'b0;
                           w_srst_nx   = 1'b0;
                           w_pluck_nx  = 1'b0;
                           w_accent_nx = 1'b0;
                        end
                     end else begin
                        w_step_nx = r_step + STEP_W'(1);
                     end
                  end
               end
            end
            S_DONE: begin
               w_state_nx = S_IDLE;
               w_step_nx  = '0;
            end
            S_IDLE: ;
            default: w_state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_step       <= '0;
         r_tcnt       <= '0;
         r_note       <= 1'b0;
         period_o     <= '0;
         string_rst_o <= 1'b0;
         pluck_o      <= 1'b0;
         accent_o     <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_step       <= w_step_nx;
         r_tcnt       <= w_tcnt_nx;
         r_note       <= w_note_nx;
         period_o     <= w_period_nx;
         string_rst_o <= w_srst_nx;
         pluck_o      <= w_pluck_nx;
         accent_o     <= w_accent_nx;
         busy_o       <= w_busy_nx;
         done_o       <= w_done_nx;
      end
   end

   assign step_o = r_step;

endmodule

`default_nettype wire

// File: tb/tb_ks_note_sequencer.sv
// ============================================================================
// Module   : tb_ks_note_sequencer
// Brief    : Self-checking bench: directed scenarios plus random stimulus
//            against a cycle-level behavioural model of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ks_note_sequencer;

   logic       clk = 1'b0;
   logic       rst, tick, start, stop, loop_en, wr_en;
   logic [3:0] last_step, gate_len, wr_addr;
   logic [7:0] tempo;
   logic [5:0] wr_data;
   logic [3:0] period_o, step_o;
   logic       string_rst_o, pluck_o, accent_o, busy_o, done_o;

   always #5 clk = ~clk;

   ks_note_sequencer dut (
      .clk_i(clk), .rst_i(rst), .tick_i(tick), .start_i(start), .stop_i(stop),
      .loop_en_i(loop_en), .last_step_i(last_step), .tempo_i(tempo),
      .gate_len_i(gate_len), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .period_o(period_o), .string_rst_o(string_rst_o),
      .pluck_o(pluck_o), .accent_o(accent_o), .step_o(step_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   int n_cmp = 0;
   int n_fail = 0;
   bit saw_pluck, saw_srst, saw_done;

   // Behavioural model: playing/done-phase flags, integer step and tick position.
   int m_mem [16];
   bit m_play, m_donep, m_note;
   int m_step, m_tcnt, m_period;
   bit m_srst, m_pluck, m_acc, m_busy, m_done;

   function automatic void model_step();
      int e, t;
      e = m_mem[m_step];
      t = (tempo == 0) ? 1 : int'(tempo);
      m_done = 0;
      if (rst) begin
         foreach (m_mem[i]) m_mem[i] = 0;
         m_play = 0; m_donep = 0; m_note = 0; m_step = 0; m_tcnt = 0; m_period = 0;
         m_srst = 0; m_pluck = 0; m_acc = 0; m_busy = 0;
         return;
      end
      if (stop && (m_play || m_donep)) begin
         m_play = 0; m_donep = 0; m_note = 0;
         m_srst = 0; m_pluck = 0; m_acc = 0; m_busy = 0;
      end else if (start && !stop) begin
         m_play = 1; m_donep = 0; m_step = 0; m_tcnt = 0; m_note = 0;
         m_srst = 0; m_pluck = 0; m_acc = 0; m_busy = 1;
      end else if (m_donep) begin
         m_donep = 0; m_step = 0;
      end else if (m_play && tick) begin
         m_pluck = m_note && (m_tcnt >= 1) && (m_tcnt <= int'(gate_len));
         if (m_tcnt == 0) begin
            m_note = e[5];
            m_srst = e[5];
            m_acc  = e[4];
            if (e[5]) m_period = e & 15;
         end else begin
            m_srst = 0;
         end
         if (m_tcnt < t) m_tcnt++;
         else begin
            m_tcnt = 0;
            if (m_step >= int'(last_step)) begin
               if (loop_en) m_step = 0;
               else begin
                  m_play = 0; m_donep = 1; m_done = 1; m_busy = 0;
                  m_srst = 0; m_pluck = 0; m_acc = 0;
               end
            end else m_step++;
         end
      end
      if (wr_en) m_mem[wr_addr] = int'(wr_data);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      logic [12:0] dv, mv;
      @(posedge clk);
      model_step();
      #1;
      dv = {period_o, string_rst_o, pluck_o, accent_o, step_o, busy_o, done_o};
      mv = {4'(m_period), m_srst, m_pluck, m_acc, 4'(m_step), m_busy, m_done};
      n_cmp++;
      if (dv !== mv) begin
         n_fail++;
         $display("FAIL model_cmp @%0t: {per,srst,pluck,acc,step,busy,done} got %h/%b/%b/%b/%h/%b/%b expected %h/%b/%b/%b/%h/%b/%b",
                  $time, period_o, string_rst_o, pluck_o, accent_o, step_o, busy_o, done_o,
                  mv[12:9], mv[8], mv[7], mv[6], mv[5:2], mv[1], mv[0]);
      end
      saw_pluck |= pluck_o;
      saw_srst  |= string_rst_o;
      saw_done  |= done_o;
      tick = 0; start = 0; stop = 0; wr_en = 0;
   endtask

   task automatic do_tick(input int spacing);
      tick = 1;
      cyc();
      repeat (spacing - 1) cyc();
   endtask

   task automatic wr(input int a, input logic [5:0] d);
      wr_en = 1; wr_addr = 4'(a); wr_data = d;
      cyc();
   endtask

   task automatic go();
      start = 1;
      cyc();
   endtask

   initial begin
      rst = 1; tick = 0; start = 0; stop = 0; loop_en = 0; wr_en = 0;
      last_step = 0; gate_len = 0; wr_addr = 0; tempo = 0; wr_data = 0;
      repeat (3) cyc();
      rst = 0;
      cyc();
      chk("reset_outputs", int'({period_o, string_rst_o, pluck_o, accent_o, step_o, busy_o, done_o}), 0);

      // All-rest pattern
      tempo = 3; gate_len = 2; last_step = 3; loop_en = 0;
      saw_pluck = 0; saw_srst = 0;
      go();
      chk("rest_busy", busy_o, 1);
      repeat (16) do_tick(2);
      chk("rest_no_pluck", saw_pluck, 0);
      chk("rest_no_srst", saw_srst, 0);
      repeat (3) cyc();

      // Two-note one-shot pass
      wr(0, 6'b10_0101);
      wr(1, 6'b11_1001);
      last_step = 1;
      go();
      for (int k = 0; k < 8; k++) begin
         tick = 1;
         cyc();
         case (k)
            0: begin chk("t0_period", period_o, 5); chk("t0_srst", string_rst_o, 1); end
            1: begin chk("t1_pluck", pluck_o, 1); chk("t1_srst", string_rst_o, 0); end
            2: chk("t2_pluck", pluck_o, 1);
            3: begin chk("t3_pluck", pluck_o, 0); chk("t3_step", step_o, 1); end
            4: begin chk("t4_period", period_o, 9); chk("t4_accent", accent_o, 1); end
            7: begin chk("t7_done", done_o, 1); chk("t7_busy", busy_o, 0); end
            default: ;
         endcase
         repeat (15) cyc();
      end
      chk("after_done_pulse", done_o, 0);
      chk("after_done_step", step_o, 0);

      // Looping, then switch to one-shot mid-run
      loop_en = 1; saw_done = 0;
      go();
      repeat (20) do_tick(2);
      chk("loop_no_done", saw_done, 0);
      loop_en = 0;
      repeat (10) do_tick(2);
      chk("loop_off_done", saw_done, 1);
      chk("loop_off_idle", busy_o, 0);

      // Tempo and gate corner cases
      loop_en = 1; tempo = 0; gate_len = 7;
      go();
      repeat (8) do_tick(2);
      tempo = 2;
      go();
      for (int k = 0; k < 4; k++) begin
         tick = 1;
         cyc();
         if (k == 1) chk("g7_t1_pluck", pluck_o, 1);
         if (k == 2) chk("g7_t2_pluck", pluck_o, 1);
         if (k == 3) chk("g7_t3_pluck", pluck_o, 0);
      end
      gate_len = 0; saw_pluck = 0;
      go();
      repeat (12) do_tick(2);
      chk("gate0_no_pluck", saw_pluck, 0);

      // Stop at tick 2 of step 0
      tempo = 3; gate_len = 2; loop_en = 0; saw_done = 0;
      go();
      repeat (3) do_tick(2);
      stop = 1;
      cyc();
      chk("stop_busy", busy_o, 0);
      chk("stop_pluck", pluck_o, 0);
      chk("stop_period", period_o, 5);
      cyc();
      chk("stop_no_done", saw_done, 0);
      start = 1; stop = 1;
      cyc();
      chk("start_stop_idle", busy_o, 0);

      // Rewrite step 1 while it plays
      loop_en = 1;
      go();
      for (int k = 0; k <= 12; k++) begin
         if (k == 5) wr(1, 6'b10_0011);
         do_tick(2);
         if (k == 4) chk("old_step1_period", period_o, 9);
         if (k == 12) chk("new_step1_period", period_o, 3);
      end

      // Reset mid-run clears outputs and memory
      rst = 1;
      cyc();
      chk("midrst_outputs", int'({period_o, string_rst_o, pluck_o, accent_o, step_o, busy_o, done_o}), 0);
      rst = 0;
      saw_pluck = 0; saw_srst = 0;
      go();
      repeat (8) do_tick(2);
      chk("midrst_mem_pluck", saw_pluck, 0);
      chk("midrst_mem_srst", saw_srst, 0);

      // Randomised run against the model
      for (int n = 0; n < 4000; n++) begin
         tick    = ($urandom_range(2) == 0);
         start   = ($urandom_range(60) == 0);
         stop    = ($urandom_range(100) == 0);
         rst     = ($urandom_range(900) == 0);
         wr_en   = ($urandom_range(7) == 0);
         wr_addr = 4'($urandom_range(15));
         wr_data = 6'($urandom);
         if ($urandom_range(40) == 0) begin
            tempo     = 8'($urandom_range(4));
            gate_len  = 4'($urandom_range(7));
            last_step = 4'($urandom_range(15));
            loop_en   = 1'($urandom);
         end
         cyc();
         rst = 0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
